fifo_read_fsm_tmr: RTL and testbench
====================================

# fifo_read_fsm_tmr

Triple-modular-redundant readout controller for the per-channel sample FIFO. After a START request it drains (SAMP_MAX+1) samples of six words each from the FIFO, with no stall bubbles while data is available and the downstream is ready. It tags every returned word with its word index and sample number, and flags any disagreement between the three redundant copies of its state. It sits between the sample FIFO read port and the readout/serialiser logic; its writer-side counterpart fills the same FIFO in the same six-word-per-sample order.

## Interface
- WORDS_PER_SAMP, 6, words per sample; fixed by the FIFO write order; word index is 3 bits.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  readout request; single-cycle pulse, sampled every cycle.
- SAMP_MAX  in  7  index of the last sample to read; latched at start of readout.
- FIFO_EMPTY  in  1  FIFO empty flag from the FIFO read port.
- DOUT_RDY  in  1  downstream can accept a word this cycle.
- RDENA  out  1  FIFO read enable; combinational from voted state.
- DATA_VLD  out  1  FIFO data output carries a requested word; RDENA delayed one cycle.
- WORD_SEL  out  3  word index 0..5 of the word flagged by DATA_VLD.
- SAMP_NUM  out  7  sample index of the word flagged by DATA_VLD.
- BUSY  out  1  readout in progress.
- DONE  out  1  one-cycle pulse after the final word has been read.
- TMR_ERR  out  1  sticky flag: replicas have disagreed at least once.

## Operation
- Registered state, word counter (sel, 3 bits), sample counter (7 bits) and latched max (7 bits) are each triplicated.
  - Every consumer uses the majority-voted value; each replica computes its own next value from voted inputs.
  - DATA_VLD, WORD_SEL, SAMP_NUM, BUSY and DONE are triplicated registers with majority-voted outputs.
- States (2 bits): Idle=00, Rst_Cnt=01, Read=10, Done=11.
- Idle:
  - START -> Rst_Cnt.
  - Otherwise stay in Idle.
- Rst_Cnt:
  - sel=0, sample=0, max=SAMP_MAX.
  - Unconditional transition -> Read.
- Read:
  - RDENA = (state==Read) & !FIFO_EMPTY & DOUT_RDY.
  - On a cycle with RDENA=1 and sel<5: sel+1.
  - On a cycle with RDENA=1 and sel==5: sel=0; if sample==max -> Done, else sample+1.
  - On a cycle with RDENA=0: counters hold and the state stays in Read. The FIFO is never read while empty.
- Done:
  - DONE=1 for this cycle.
  - START -> Rst_Cnt, otherwise -> Idle.
- START while in Read aborts the readout and goes to Rst_Cnt; counters restart from 0.
  - A read in that same cycle still completes, so DATA_VLD still follows one cycle later.
- Arithmetic:
  - sample counter is 7-bit and never passes max.
  - SAMP_MAX=127 gives 768 words.
  - SAMP_MAX=0 gives 6 words.
- Illegal or unknown voted state decodes to Idle next.
- TMR_ERR is set on any cycle where the three replicas of state, sel, sample or max are not all equal.
  - It is cleared only by RST.
  - A single upset replica is outvoted and realigned on the next clock.
- Reset mid-readout: all replicas and all outputs go to 0 immediately (RDENA drops combinationally). No DONE is issued.

## Timing
- Reset values: RDENA=0, DATA_VLD=0, WORD_SEL=0, SAMP_NUM=0, BUSY=0, DONE=0, TMR_ERR=0; state Idle.
- START sampled in cycle n:
  - Rst_Cnt in n+1.
  - Read in n+2; first RDENA possible in n+2.
  - First DATA_VLD in n+3, with WORD_SEL=0 and SAMP_NUM=0.
- Streaming throughput is one word per cycle. FIFO read latency is one cycle, so DATA_VLD = RDENA registered.
- WORD_SEL and SAMP_NUM are the pre-increment counter values registered alongside DATA_VLD.
- BUSY is 1 from n+1 through the last Read cycle; it is 0 in Done and Idle.
- Last read in cycle m:
  - Done in m+1, with DONE=1 and the last DATA_VLD (WORD_SEL=5, SAMP_NUM=max) in m+1.
  - Idle in m+2.
- TMR_ERR rises one cycle after the mismatch.

## Structure
- Package fifo_rd_pkg:
  - state encodings Idle/Rst_Cnt/Read/Done.
  - WORDS_PER_SAMP=6, LAST_SEL=3'd5.
  - widths SEL_W=3, SAMP_W=7.
- Sub-module maj3_vote:
  - parameterised width W.
  - inputs a, b, c; outputs the bitwise majority and a mismatch bit (a!=b | b!=c).
  - instanced once per triplicated register group; the mismatch bits are ORed into TMR_ERR.

## Test plan
- Reset, then START with SAMP_MAX=2, FIFO_EMPTY=0, DOUT_RDY=1 -> 18 consecutive RDENA cycles; DATA_VLD WORD_SEL/SAMP_NUM sequence 0..5 for each of samples 0,1,2; DONE pulse in the cycle after the last read, then Idle.
- Same run with FIFO_EMPTY=1 for 3 cycles at word 3 of sample 1 -> RDENA=0 for those cycles, counters hold, sequence resumes at word 3 with no loss or duplication.
- DOUT_RDY toggled every other cycle with SAMP_MAX=0 -> exactly 6 reads in 11 cycles, all ordered 0..5, DONE once.
- START again at word 4 of sample 1 (SAMP_MAX=3) -> in-flight word still validated, counters restart at 0/0, full 24-word readout follows.
- Force one replica of the sample counter to 7'h55 mid-run -> outputs unaffected, TMR_ERR=1 next cycle and stays 1; RST clears it.
- RST asserted mid-readout -> all outputs 0 asynchronously, no DONE; a following START gives a clean readout.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the TMR sample-FIFO readout controller.
package fifo_rd_pkg;

    localparam int WORDS_PER_SAMP = 6;
    localparam int SEL_W          = 3;
    localparam int SAMP_W         = 7;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORDS_PER_SAMP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RST_CNT = 2'b01,
        ST_READ    = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // Registered outputs, triplicated and voted as one group.
    typedef struct packed {
        logic              vld;
        logic [SEL_W-1:0]  wsel;
        logic [SAMP_W-1:0] snum;
        logic              busy;
        logic              done;
    } out_t;

endpackage

// File: rtl/fifo_read_fsm_tmr_vote.sv
// Bitwise 2-of-3 majority voter with a replica-disagreement flag.
module maj3_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_maj,
    output logic         o_mis
);

    assign o_maj = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);
    assign o_mis = (i_a != i_b) | (i_b != i_c);

endmodule

// File: rtl/fifo_read_fsm_tmr.sv
// Triplicated FIFO readout FSM: drains (SAMP_MAX+1) six-word samples, one word per cycle.
// DATA_VLD lags RDENA by one cycle; reads stall while FIFO_EMPTY or !DOUT_RDY.
module fifo_read_fsm_tmr
    import fifo_rd_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [SAMP_W-1:0] SAMP_MAX,
    input  logic              FIFO_EMPTY,
    input  logic              DOUT_RDY,
    output logic              RDENA,
    output logic              DATA_VLD,
    output logic [SEL_W-1:0]  WORD_SEL,
    output logic [SAMP_W-1:0] SAMP_NUM,
    output logic              BUSY,
    output logic              DONE,
    output logic              TMR_ERR
);

    logic [1:0]        w_state_v;
    state_t            w_state;
    logic [SEL_W-1:0]  w_sel;
    logic [SAMP_W-1:0] w_samp;
    logic [SAMP_W-1:0] w_max;
    out_t              w_out;
    logic              w_rdena;
    logic              w_mis_state, w_mis_sel, w_mis_samp, w_mis_max, w_mis_out;
    logic              r_tmr_err;

    assign w_state = state_t'(w_state_v);
    assign w_rdena = (w_state == ST_READ) & ~FIFO_EMPTY & DOUT_RDY;

    for (genvar g = 0; g < 3; g++) begin : g_rep
        state_t            r_state, w_nxt_state;
        logic [SEL_W-1:0]  r_sel, w_nxt_sel;
        logic [SAMP_W-1:0] r_samp, w_nxt_samp;
        logic [SAMP_W-1:0] r_max, w_nxt_max;
        out_t              r_out, w_nxt_out;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_state <= ST_IDLE;
                r_sel   <= '0;
                r_samp  <= '0;
                r_max   <= '0;
                r_out   <= '0;
            end else begin
                r_state <= w_nxt_state;
                r_sel   <= w_nxt_sel;
                r_samp  <= w_nxt_samp;
                r_max   <= w_nxt_max;
                r_out   <= w_nxt_out;
            end
        end

        // Next state is derived from voted values only, so an upset replica realigns.
        always_comb begin
            w_nxt_state = w_state;
            w_nxt_sel   = w_sel;
            w_nxt_samp  = w_samp;
            w_nxt_max   = w_max;
            case (w_state)
                ST_IDLE: begin
                    if (START) w_nxt_state = ST_RST_CNT;
                end
                ST_RST_CNT: begin
                    w_nxt_sel   = '0;
                    w_nxt_samp  = '0;
                    w_nxt_max   = SAMP_MAX;
                    w_nxt_state = ST_READ;
                end
                ST_READ: begin
                    if (w_rdena) begin
                        if (w_sel == LAST_SEL) begin
                            w_nxt_sel = '0;
                            if (w_samp == w_max) w_nxt_state = ST_DONE;
                            else                 w_nxt_samp  = w_samp + 7'd1;
                        end else begin
                            w_nxt_sel = w_sel + 3'd1;
                        end
                    end
                    if (START) w_nxt_state = ST_RST_CNT;
                end
                ST_DONE: begin
                    w_nxt_state = START ? ST_RST_CNT : ST_IDLE;
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end

        always_comb begin
            w_nxt_out      = w_out;
            w_nxt_out.vld  = w_rdena;
            if (w_rdena) begin
                w_nxt_out.wsel = w_sel;
                w_nxt_out.snum = w_samp;
            end
            w_nxt_out.busy = (w_nxt_state == ST_RST_CNT) || (w_nxt_state == ST_READ);
            w_nxt_out.done = (w_nxt_state == ST_DONE);
        end
    end

    maj3_vote #(.W(2)) u_vote_state (
        .i_a(g_rep[0].r_state), .i_b(g_rep[1].r_state), .i_c(g_rep[2].r_state),
        .o_maj(w_state_v), .o_mis(w_mis_state)
    );
    maj3_vote #(.W(SEL_W)) u_vote_sel (
        .i_a(g_rep[0].r_sel), .i_b(g_rep[1].r_sel), .i_c(g_rep[2].r_sel),
        .o_maj(w_sel), .o_mis(w_mis_sel)
    );
    maj3_vote #(.W(SAMP_W)) u_vote_samp (
        .i_a(g_rep[0].r_samp), .i_b(g_rep[1].r_samp), .i_c(g_rep[2].r_samp),
        .o_maj(w_samp), .o_mis(w_mis_samp)
    );
    maj3_vote #(.W(SAMP_W)) u_vote_max (
        .i_a(g_rep[0].r_max), .i_b(g_rep[1].r_max), .i_c(g_rep[2].r_max),
        .o_maj(w_max), .o_mis(w_mis_max)
    );
    maj3_vote #(.W($bits(out_t))) u_vote_out (
        .i_a(g_rep[0].r_out), .i_b(g_rep[1].r_out), .i_c(g_rep[2].r_out),
        .o_maj(w_out), .o_mis(w_mis_out)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_tmr_err <= 1'b0;
        else     r_tmr_err <= r_tmr_err | w_mis_state | w_mis_sel | w_mis_samp
                                        | w_mis_max | w_mis_out;
    end

    assign RDENA    = w_rdena;
    assign DATA_VLD = w_out.vld;
    assign WORD_SEL = w_out.wsel;
    assign SAMP_NUM = w_out.snum;
    assign BUSY     = w_out.busy;
    assign DONE     = w_out.done;
    assign TMR_ERR  = r_tmr_err;

endmodule

// File: tb/tb_fifo_read_fsm_tmr.sv
// Directed bench for fifo_read_fsm_tmr; expected words come from a per-cycle read count.
module tb_fifo_read_fsm_tmr;

    logic       CLK, RST, START, FIFO_EMPTY, DOUT_RDY;
    logic [6:0] SAMP_MAX;
    logic       RDENA, DATA_VLD, BUSY, DONE, TMR_ERR;
    logic [2:0] WORD_SEL;
    logic [6:0] SAMP_NUM;

    int total = 0;
    int bad   = 0;
    int n;

    fifo_read_fsm_tmr dut (
        .CLK(CLK), .RST(RST), .START(START), .SAMP_MAX(SAMP_MAX),
        .FIFO_EMPTY(FIFO_EMPTY), .DOUT_RDY(DOUT_RDY), .RDENA(RDENA),
        .DATA_VLD(DATA_VLD), .WORD_SEL(WORD_SEL), .SAMP_NUM(SAMP_NUM),
        .BUSY(BUSY), .DONE(DONE), .TMR_ERR(TMR_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdena"}, RDENA, 0);
        chk({tag, "_vld"},   DATA_VLD, 0);
        chk({tag, "_wsel"},  WORD_SEL, 0);
        chk({tag, "_snum"},  SAMP_NUM, 0);
        chk({tag, "_busy"},  BUSY, 0);
        chk({tag, "_done"},  DONE, 0);
        chk({tag, "_tmr"},   TMR_ERR, 0);
    endtask

    // START pulse, then one Rst_Cnt cycle; returns with the DUT in Read.
    task automatic start_read(input int maxs);
        START = 1'b1;
        SAMP_MAX = maxs[6:0];
        tick();
        START = 1'b0;
        FIFO_EMPTY = 1'b0;
        DOUT_RDY = 1'b1;
        #1;
        chk("rst_cnt_busy", BUSY, 1);
        chk("rst_cnt_rdena", RDENA, 0);
        tick();
        chk("read_entry_vld", DATA_VLD, 0);
    endtask

    // Drives one readout cycle by cycle and checks every word against the bench's own count.
    task automatic run(input int maxs, input int stall_k, input int stall_n, input bit toggle,
                       input int abort_k, input int upset_k, input int stop_k,
                       output int cycles);
        int words;
        int k;
        int stalled;
        bit emp, rdy, rd, ab, up;
        words = (maxs + 1) * 6;
        k = 0;
        stalled = 0;
        cycles = 0;
        while (k < words && k != stop_k && cycles < 600) begin
            emp = (k == stall_k) && (stalled < stall_n);
            if (emp) stalled++;
            rdy = toggle ? (cycles % 2 == 0) : 1'b1;
            rd  = !emp && rdy;
            ab  = (k == abort_k) && rd;
            up  = (k == upset_k);
            FIFO_EMPTY = emp;
            DOUT_RDY   = rdy;
            START      = ab;
            if (up) force dut.g_rep[1].r_samp = 7'h55;
            #1;
            chk("rdena", RDENA, rd);
            if (up) chk("tmr_before_edge", TMR_ERR, 0);
            tick();
            cycles++;
            if (up) begin
                release dut.g_rep[1].r_samp;
                chk("tmr_after_upset", TMR_ERR, 1);
            end
            chk("vld", DATA_VLD, rd);
            if (rd) begin
                chk("wsel", WORD_SEL, k % 6);
                chk("snum", SAMP_NUM, k / 6);
                k++;
            end
            chk("done", DONE, (k == words) && rd);
            chk("busy", BUSY, (k < words) || ab);
            if (ab) begin
                START = 1'b0;
                break;
            end
        end
        if (cycles >= 600) chk("cycle_budget", k, words);
    endtask

    // Done cycle then return to Idle.
    task automatic finish_chk();
        FIFO_EMPTY = 1'b0;
        DOUT_RDY = 1'b1;
        #1;
        chk("done_rdena", RDENA, 0);
        tick();
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
        chk("idle_vld", DATA_VLD, 0);
        #1;
        chk("idle_rdena", RDENA, 0);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        SAMP_MAX = '0;
        FIFO_EMPTY = 1'b1;
        DOUT_RDY = 1'b0;
        #12;
        chk_all_zero("reset");
        RST = 1'b0;
        tick();

        // Uninterrupted stream, three samples.
        start_read(2);
        run(2, -1, 0, 0, -1, -1, -1, n);
        chk("stream_cycles", n, 18);
        finish_chk();

        // FIFO empty for three cycles at word 3 of sample 1.
        start_read(2);
        run(2, 9, 3, 0, -1, -1, -1, n);
        chk("stall_cycles", n, 21);
        finish_chk();

        // Downstream ready every other cycle, single sample.
        start_read(0);
        run(0, -1, 0, 1, -1, -1, -1, n);
        chk("toggle_cycles", n, 11);
        finish_chk();

        // Restart at word 4 of sample 1, then a full four-sample readout.
        start_read(3);
        run(3, -1, 0, 0, 10, -1, -1, n);
        chk("abort_cycles", n, 11);
        #1;
        chk("abort_rst_cnt_rdena", RDENA, 0);
        tick();
        chk("abort_read_entry_vld", DATA_VLD, 0);
        run(3, -1, 0, 0, -1, -1, -1, n);
        chk("restart_cycles", n, 24);
        finish_chk();

        // Upset one sample-counter replica mid-run.
        start_read(2);
        run(2, -1, 0, 0, -1, 8, -1, n);
        chk("upset_cycles", n, 18);
        chk("tmr_sticky", TMR_ERR, 1);
        finish_chk();
        chk("tmr_sticky_idle", TMR_ERR, 1);
        RST = 1'b1;
        #1;
        chk("tmr_cleared", TMR_ERR, 0);
        RST = 1'b0;
        tick();

        // Reset in the middle of a readout.
        start_read(2);
        run(2, -1, 0, 0, -1, -1, 7, n);
        chk("partial_cycles", n, 7);
        RST = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick();
        chk("mid_reset_done1", DONE, 0);
        tick();
        chk("mid_reset_done2", DONE, 0);
        RST = 1'b0;
        tick();
        start_read(1);
        run(1, -1, 0, 0, -1, -1, -1, n);
        chk("post_reset_cycles", n, 12);
        finish_chk();
        chk("post_reset_tmr", TMR_ERR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
